// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared digit width, constants and FSM encoding for the microwave timer
// Contents: DIGIT_W (BCD digit width), MAX_DIGIT (largest accepted key),
// TENS_BORROW (tens-of-seconds value after a minute borrow), bcd_t, state_t.
package microwave_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam bcd_t MAX_DIGIT   = 4'd9;
  localparam bcd_t TENS_BORROW = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/microwave_tick_gen.sv
// rtl/microwave_tick_gen.sv - one-second prescaler for the microwave timer
// Ports: clk, rst (sync active-high), clr (restart the second),
// en (count this cycle), sec_tick (high on the enabled cycle that completes a second).
module microwave_tick_gen
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic sec_tick
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt;

  // The tick fires in the same cycle the counter wraps, so the second
  // completes on the TICKS_PER_SEC-th enabled edge after a clear.
  assign sec_tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/microwave_timer.sv
// rtl/microwave_timer.sv - M:SS BCD countdown timer with keypad entry and sticky done flag
// Ports: clk, rst (sync active-high), clrn (panel clear, active low),
// key_valid/key_digit (keypad digit pulse), mag_on (count enable),
// min_ones/sec_tens/sec_ones (BCD display), timer_done (registered, sticky).
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clrn,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               mag_on,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               timer_done
);

  logic   clear;
  logic   key_accept;
  logic   sec_tick;
  logic   cnt_zero;
  logic   dec_zero;
  bcd_t   dec_min;
  bcd_t   dec_tens;
  bcd_t   dec_ones;
  state_t state;

  assign clear      = !clrn;
  // Keys are locked out while the magnetron runs, so a key never races a tick.
  assign key_accept = key_valid && !mag_on && (key_digit <= MAX_DIGIT);
  assign cnt_zero   = (min_ones == '0) && (sec_tens == '0) && (sec_ones == '0);

  microwave_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .clr     (clear || key_accept),
    .en      (mag_on),
    .sec_tick(sec_tick)
  );

  // Next count after one second; a minute borrow reloads tens with 5, not 9.
  always_comb begin
    dec_min  = min_ones;
    dec_tens = sec_tens;
    dec_ones = sec_ones;
    if (sec_ones != '0) begin
      dec_ones = sec_ones - 4'd1;
    end else if (sec_tens != '0) begin
      dec_ones = MAX_DIGIT;
      dec_tens = sec_tens - 4'd1;
    end else if (min_ones != '0) begin
      dec_ones = MAX_DIGIT;
      dec_tens = TENS_BORROW;
      dec_min  = min_ones - 4'd1;
    end
  end

  assign dec_zero = (dec_min == '0) && (dec_tens == '0) && (dec_ones == '0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      min_ones   <= '0;
      sec_tens   <= '0;
      sec_ones   <= '0;
      timer_done <= 1'b0;
      state      <= ST_IDLE;
    end else if (key_accept) begin
      min_ones   <= sec_tens;
      sec_tens   <= sec_ones;
      sec_ones   <= key_digit;
      timer_done <= 1'b0;
      state      <= ST_IDLE;
    end else begin
      if (sec_tick) begin
        min_ones <= dec_min;
        sec_tens <= dec_tens;
        sec_ones <= dec_ones;
      end
      if (mag_on && (cnt_zero || (sec_tick && dec_zero))) begin
        timer_done <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (mag_on) begin
            state <= cnt_zero ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (!mag_on) begin
            state <= ST_PAUSE;
          end else if (sec_tick && dec_zero) begin
            state <= ST_DONE;
          end
        end
        ST_PAUSE: begin
          if (mag_on) begin
            state <= ST_RUN;
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microwave_timer.sv
// tb/tb_microwave_timer.sv - self-checking bench for microwave_timer
module tb_microwave_timer;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       clrn;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       mag_on;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       timer_done;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference state: minutes and a two-digit seconds value kept as integers.
  int m_min  = 0;
  int m_secs = 0;
  int m_en   = 0;
  bit m_done = 1'b0;

  microwave_timer #(
    .TICKS_PER_SEC(TPS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clrn      (clrn),
    .key_valid (key_valid),
    .key_digit (key_digit),
    .mag_on    (mag_on),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .timer_done(timer_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit was_zero;
    if (rst || !clrn) begin
      m_min  = 0;
      m_secs = 0;
      m_en   = 0;
      m_done = 1'b0;
    end else if (key_valid && !mag_on && key_digit <= 9) begin
      m_min  = m_secs / 10;
      m_secs = (m_secs % 10) * 10 + int'(key_digit);
      m_en   = 0;
      m_done = 1'b0;
    end else if (mag_on) begin
      was_zero = (m_min == 0) && (m_secs == 0);
      m_en++;
      if (m_en == TPS) begin
        m_en = 0;
        if (m_secs > 0) begin
          m_secs--;
        end else if (m_min > 0) begin
          m_min--;
          m_secs = 59;
        end
        if (!was_zero && m_min == 0 && m_secs == 0) m_done = 1'b1;
      end
      if (was_zero) m_done = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_min_ones", int'(min_ones), m_min);
      check("model_sec_tens", int'(sec_tens), m_secs / 10);
      check("model_sec_ones", int'(sec_ones), m_secs % 10);
      check("model_timer_done", int'(timer_done), int'(m_done));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    @(negedge clk);
    key_valid = 1'b0;
    key_digit = 4'd0;
  endtask

  task automatic expect_time(input string name, input int m, input int t, input int o,
                             input int d);
    check({name, "_min"}, int'(min_ones), m);
    check({name, "_tens"}, int'(sec_tens), t);
    check({name, "_ones"}, int'(sec_ones), o);
    check({name, "_done"}, int'(timer_done), d);
  endtask

  initial begin
    rst       = 1'b1;
    clrn      = 1'b1;
    key_valid = 1'b0;
    key_digit = 4'd0;
    mag_on    = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    expect_time("reset", 0, 0, 0, 0);
    rst = 1'b0;

    press(4'd1);
    press(4'd3);
    press(4'd0);
    expect_time("entry_130", 1, 3, 0, 0);
    press(4'd12);
    expect_time("bad_digit", 1, 3, 0, 0);

    press(4'd0);
    press(4'd0);
    press(4'd2);
    expect_time("entry_002", 0, 0, 2, 0);
    mag_on = 1'b1;
    cycles(4);
    expect_time("run_001", 0, 0, 1, 0);
    cycles(4);
    expect_time("run_000", 0, 0, 0, 1);
    cycles(8);
    expect_time("hold_000", 0, 0, 0, 1);
    mag_on = 1'b0;
    cycles(3);
    expect_time("done_latched", 0, 0, 0, 1);

    press(4'd1);
    press(4'd0);
    press(4'd0);
    expect_time("entry_100", 1, 0, 0, 0);
    mag_on = 1'b1;
    cycles(4);
    expect_time("borrow_059", 0, 5, 9, 0);
    mag_on = 1'b0;

    press(4'd0);
    press(4'd0);
    press(4'd5);
    mag_on = 1'b1;
    cycles(2);
    mag_on = 1'b0;
    cycles(10);
    expect_time("paused_005", 0, 0, 5, 0);
    mag_on = 1'b1;
    cycles(1);
    press(4'd7);
    expect_time("resume_004", 0, 0, 4, 0);

    cycles(4);
    expect_time("run_003", 0, 0, 3, 0);
    clrn = 1'b0;
    cycles(1);
    clrn = 1'b1;
    expect_time("clear_run", 0, 0, 0, 0);
    cycles(1);
    expect_time("zero_start", 0, 0, 0, 1);
    mag_on = 1'b0;

    press(4'd9);
    press(4'd9);
    press(4'd9);
    expect_time("entry_999", 9, 9, 9, 0);
    mag_on = 1'b1;
    cycles(4);
    expect_time("run_998", 9, 9, 8, 0);
    mag_on = 1'b0;

    press(4'd0);
    press(4'd7);
    press(4'd0);
    mag_on = 1'b1;
    cycles(4);
    expect_time("tens7_069", 0, 6, 9, 0);
    mag_on = 1'b0;
    cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
